// File: rtl/stream_downsizer_if.sv
// Handshake bundle between a wide-word source, the downsizer and a narrow consumer.
// out_last is present only when STREAM_DOWNSIZER_LAST_EN is defined.
interface stream_downsizer_if #(
    parameter int unsigned in_width = 32,
    parameter int unsigned ratio    = 4
);
    localparam int unsigned out_width = in_width / ratio;

    logic [in_width-1:0]  in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [out_width-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 flush;
    logic                 busy;
`ifdef STREAM_DOWNSIZER_LAST_EN
    logic                 out_last;
`endif

    modport slave (
        input  in_data, in_valid, out_ready, flush,
`ifdef STREAM_DOWNSIZER_LAST_EN
        output out_last,
`endif
        output in_ready, out_data, out_valid, busy
    );

    modport master (
        output in_data, in_valid, out_ready, flush,
`ifdef STREAM_DOWNSIZER_LAST_EN
        input  out_last,
`endif
        input  in_ready, out_data, out_valid, busy
    );
endinterface

// File: rtl/stream_downsizer.sv
// Wide-to-narrow stream converter: one in_width word becomes ratio beats, LSB slice first.
// Optional out_last beat marker enabled by defining STREAM_DOWNSIZER_LAST_EN.
module stream_downsizer #(
    parameter int unsigned in_width = 32,
    parameter int unsigned ratio    = 4
) (
    input  logic              clk,
    input  logic              rst,
    stream_downsizer_if.slave bus
);
    localparam int unsigned out_width = in_width / ratio;
    localparam int unsigned beat_w    = (ratio > 1) ? $clog2(ratio) : 1;
    localparam logic [beat_w-1:0] last_beat = beat_w'(ratio - 1);

    if (ratio < 2 || (in_width % ratio) != 0) begin : g_bad_cfg
        $fatal(1, "stream_downsizer: ratio must be >= 2 and divide in_width exactly");
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state_q;
    logic [beat_w-1:0]    beat_q;
    logic [in_width-1:0]  word_q;
    logic [out_width-1:0] slice;
    logic                 at_last;
    logic                 out_fire;
    logic                 in_fire;

    assign at_last       = (beat_q == last_beat);
    assign bus.out_valid = (state_q == SHIFT) && !rst;
    assign bus.busy      = (state_q == SHIFT) && !rst;
    assign out_fire      = bus.out_valid && bus.out_ready;
    // Reload is allowed on the last-beat handshake so consecutive words run bubble-free.
    assign bus.in_ready  = !rst && !bus.flush && (state_q == IDLE || (out_fire && at_last));
    assign in_fire       = bus.in_valid && bus.in_ready;

    always_comb begin
        slice = '0;
        for (int unsigned i = 0; i < ratio; i++) begin
            if (beat_q == beat_w'(i)) slice = word_q[i*out_width +: out_width];
        end
    end

    assign bus.out_data = rst ? '0 : slice;

`ifdef STREAM_DOWNSIZER_LAST_EN
    assign bus.out_last = bus.out_valid && at_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            word_q  <= '0;
        end else if (bus.flush) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_fire) begin
                        word_q  <= bus.in_data;
                        beat_q  <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (out_fire) begin
                        if (!at_last) begin
                            beat_q <= beat_q + beat_w'(1);
                        end else if (in_fire) begin
                            word_q <= bus.in_data;
                            beat_q <= '0;
                        end else begin
                            beat_q  <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    beat_q  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stream_downsizer.sv
// Bench for stream_downsizer (in_width=32, ratio=4): per-cycle vector table, corner sequences,
// and a beat scoreboard fed on every accepted word.
module tb_stream_downsizer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    stream_downsizer_if #(.in_width(32), .ratio(4)) bus ();

    stream_downsizer #(.in_width(32), .ratio(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t sb[$];

    // Scoreboard: pop on every output handshake, push the four slices on every accepted word.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_beat", {24'd0, bus.out_data}, 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("sb_data", {24'd0, bus.out_data}, {24'd0, e.data});
`ifdef STREAM_DOWNSIZER_LAST_EN
                    chk("sb_last", {31'd0, bus.out_last}, {31'd0, e.last});
`endif
                end
            end
            if (bus.flush) sb.delete();
            if (bus.in_valid && bus.in_ready) begin
                for (int k = 0; k < 4; k++) begin
                    beat_t b;
                    b.data = bus.in_data[k*8 +: 8];
                    b.last = (k == 3);
                    sb.push_back(b);
                end
            end
        end
    end

    typedef struct {
        logic        rst, fl, iv, ordy;
        logic [31:0] data;
        logic        e_ir, e_ov, e_busy, e_last;
        logic [7:0]  e_od;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, fl, iv, ordy, input logic [31:0] d,
                       input logic ir, ov, bsy, lst, input logic [7:0] od);
        vec_t v;
        v = '{r, fl, iv, ordy, d, ir, ov, bsy, lst, od};
        vecs.push_back(v);
    endtask

    task automatic cyc(input logic r, fl, iv, ordy, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst           = r;
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        bus.in_data   = d;
        @(negedge clk);
    endtask

    initial begin
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_data = '0;

        // reset with in_valid high, then word DDCCBBAA
        for (int i = 0; i < 3; i++) add(1, 0, 1, 1, 32'hDDCCBBAA, 0, 0, 0, 0, 8'h00);
        add(0, 0, 1, 1, 32'hDDCCBBAA, 1, 0, 0, 0, 8'h00);
        add(0, 0, 0, 1, 32'h0, 0, 1, 1, 0, 8'hAA);
        add(0, 0, 0, 1, 32'h0, 0, 1, 1, 0, 8'hBB);
        add(0, 0, 0, 1, 32'h0, 0, 1, 1, 0, 8'hCC);
        add(0, 0, 0, 1, 32'h0, 1, 1, 1, 1, 8'hDD);
        add(0, 0, 0, 1, 32'h0, 1, 0, 0, 0, 8'hAA);
        // back-to-back words, no bubble
        add(0, 0, 1, 1, 32'h44332211, 1, 0, 0, 0, 8'hAA);
        add(0, 0, 1, 1, 32'h88776655, 0, 1, 1, 0, 8'h11);
        add(0, 0, 1, 1, 32'h88776655, 0, 1, 1, 0, 8'h22);
        add(0, 0, 1, 1, 32'h88776655, 0, 1, 1, 0, 8'h33);
        add(0, 0, 1, 1, 32'h88776655, 1, 1, 1, 1, 8'h44);
        add(0, 0, 0, 1, 32'h0, 0, 1, 1, 0, 8'h55);
        add(0, 0, 0, 1, 32'h0, 0, 1, 1, 0, 8'h66);
        add(0, 0, 0, 1, 32'h0, 0, 1, 1, 0, 8'h77);
        add(0, 0, 0, 1, 32'h0, 1, 1, 1, 1, 8'h88);
        add(0, 0, 0, 1, 32'h0, 1, 0, 0, 0, 8'h55);
        // stalls 1,0,0,1 on word 0A0B0C0D; stall on last beat blocks input
        add(0, 0, 1, 1, 32'h0A0B0C0D, 1, 0, 0, 0, 8'h55);
        add(0, 0, 0, 1, 32'h0, 0, 1, 1, 0, 8'h0D);
        add(0, 0, 0, 0, 32'h0, 0, 1, 1, 0, 8'h0C);
        add(0, 0, 0, 0, 32'h0, 0, 1, 1, 0, 8'h0C);
        add(0, 0, 0, 1, 32'h0, 0, 1, 1, 0, 8'h0C);
        add(0, 0, 0, 1, 32'h0, 0, 1, 1, 0, 8'h0B);
        add(0, 0, 1, 0, 32'h12345678, 0, 1, 1, 1, 8'h0A);
        add(0, 0, 1, 1, 32'h12345678, 1, 1, 1, 1, 8'h0A);
        add(0, 0, 0, 1, 32'h0, 0, 1, 1, 0, 8'h78);
        add(0, 0, 0, 1, 32'h0, 0, 1, 1, 0, 8'h56);
        add(0, 0, 0, 1, 32'h0, 0, 1, 1, 0, 8'h34);
        add(0, 0, 0, 1, 32'h0, 1, 1, 1, 1, 8'h12);
        add(0, 0, 0, 1, 32'h0, 1, 0, 0, 0, 8'h78);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].data);
            chk($sformatf("v%0d_in_ready", i),  {31'd0, bus.in_ready},  {31'd0, vecs[i].e_ir});
            chk($sformatf("v%0d_out_valid", i), {31'd0, bus.out_valid}, {31'd0, vecs[i].e_ov});
            chk($sformatf("v%0d_busy", i),      {31'd0, bus.busy},      {31'd0, vecs[i].e_busy});
            chk($sformatf("v%0d_out_data", i),  {24'd0, bus.out_data},  {24'd0, vecs[i].e_od});
`ifdef STREAM_DOWNSIZER_LAST_EN
            chk($sformatf("v%0d_out_last", i),  {31'd0, bus.out_last},  {31'd0, vecs[i].e_last});
`endif
        end

        // flush after the second beat
        cyc(0, 0, 1, 1, 32'h11223344); chk("fl_accept", {31'd0, bus.in_ready}, 32'd1);
        cyc(0, 0, 0, 1, 32'h0);        chk("fl_b0", {24'd0, bus.out_data}, 32'h44);
        cyc(0, 0, 0, 1, 32'h0);        chk("fl_b1", {24'd0, bus.out_data}, 32'h33);
        cyc(0, 1, 1, 1, 32'h55667788);
        chk("fl_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("fl_ov_in_flush", {31'd0, bus.out_valid}, 32'd1);
        cyc(0, 0, 1, 1, 32'h55667788);
        chk("fl_after_ov", {31'd0, bus.out_valid}, 32'd0);
        chk("fl_after_busy", {31'd0, bus.busy}, 32'd0);
        chk("fl_after_ir", {31'd0, bus.in_ready}, 32'd1);
        cyc(0, 0, 0, 1, 32'h0);        chk("fl_next_b0", {24'd0, bus.out_data}, 32'h88);
        chk("fl_next_ov", {31'd0, bus.out_valid}, 32'd1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 32'h0);

        // reset mid-word at beat 2
        cyc(0, 0, 1, 1, 32'hCAFEF00D);
        cyc(0, 0, 0, 1, 32'h0);        chk("rs_b0", {24'd0, bus.out_data}, 32'h0D);
        cyc(0, 0, 0, 1, 32'h0);        chk("rs_b1", {24'd0, bus.out_data}, 32'hF0);
        cyc(1, 0, 1, 1, 32'h0);
        chk("rs_ov", {31'd0, bus.out_valid}, 32'd0);
        chk("rs_ir", {31'd0, bus.in_ready}, 32'd0);
        chk("rs_od", {24'd0, bus.out_data}, 32'd0);
        cyc(0, 0, 0, 1, 32'h0);
        chk("rs_post_ov", {31'd0, bus.out_valid}, 32'd0);
        chk("rs_post_busy", {31'd0, bus.busy}, 32'd0);
        chk("rs_post_od", {24'd0, bus.out_data}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 32'h0);
            chk("rs_idle_ov", {31'd0, bus.out_valid}, 32'd0);
        end
        cyc(0, 0, 1, 1, 32'h99AABBCC);
        cyc(0, 0, 0, 1, 32'h0);        chk("rs_new_b0", {24'd0, bus.out_data}, 32'hCC);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 32'h0);

        // random traffic with occasional flush, checked by the scoreboard
        for (int i = 0; i < 400; i++) begin
            cyc(0, ($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), $urandom);
        end
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 32'h0);
        chk("drain_busy", {31'd0, bus.busy}, 32'd0);
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
